// File: rtl/freq_meas_sched.sv
`default_nettype none
// ============================================================================
// Module   : freq_meas_sched
// Brief    : Round-robin frequency meter; one gated edge counter time-shared
//            across NUM_CH asynchronous inputs, results on a valid/ready stream.
//            Define FREQ_MEAS_STUCK_EN to report empty windows as the all-ones
//            "no clock" code with a stuck flag.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meas_sched #(
   parameter int NUM_CH        = 4,
   parameter int GATE_CYCLES   = 86000000,
   parameter int CNT_W         = 32,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         sig_in,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic                      run,
   output logic [CNT_W-1:0]          res_data,
   output logic [$clog2(NUM_CH)-1:0] res_ch,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      busy,
`ifdef FREQ_MEAS_STUCK_EN
   output logic                      stuck,
`endif
   output logic                      sat
);

   localparam int c_CH_W = $clog2(NUM_CH);
   // The gate counter must reach GATE_CYCLES even when results are narrow.
   localparam int c_GCNT_W = ($clog2(GATE_CYCLES) > CNT_W) ? $clog2(GATE_CYCLES) : CNT_W;
   localparam logic [c_GCNT_W-1:0] c_GATE_LAST   = c_GCNT_W'(GATE_CYCLES - 1);
   localparam logic [c_GCNT_W-1:0] c_SETTLE_LAST = c_GCNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    c_CNT_MAX     = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_SETTLE = 3'd2,
      ST_GATE   = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_CH_W-1:0]   r_ch_ptr, w_ch_ptr_nxt, w_ptr_inc;
   logic                r_sync1, r_sync2, r_hist;
   logic                w_rise;
   logic [c_GCNT_W-1:0] r_gate_cnt, w_gate_nxt;
   logic [CNT_W-1:0]    r_edge_cnt, w_edge_nxt, w_edge_inc;
   logic                r_sat_flag, w_sat_flag_nxt, w_sat_inc;
   logic [CNT_W-1:0]    r_res_data, w_res_data_nxt;
   logic [c_CH_W-1:0]   r_res_ch, w_res_ch_nxt;
   logic                r_res_valid, w_res_valid_nxt;
   logic                r_res_sat, w_res_sat_nxt;
`ifdef FREQ_MEAS_STUCK_EN
   logic                r_res_stuck, w_res_stuck_nxt;
`endif

   logic                w_found;
   logic [c_CH_W-1:0]   w_found_idx;
   logic [c_CH_W:0]     w_d, w_best_d;

   assign w_rise    = r_sync2 & ~r_hist;
   assign w_ptr_inc = (r_ch_ptr == c_CH_W'(NUM_CH - 1)) ? '0 : r_ch_ptr + 1'b1;

   // First enabled channel at or after ch_ptr, by wrapped distance.
   always_comb begin
      w_found     = 1'b0;
      w_found_idx = '0;
      w_best_d    = '0;
      w_d         = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (c_CH_W'(j) >= r_ch_ptr)
            w_d = {1'b0, c_CH_W'(j)} - {1'b0, r_ch_ptr};
         else
            w_d = {1'b0, c_CH_W'(j)} + (c_CH_W+1)'(NUM_CH) - {1'b0, r_ch_ptr};
         if (ch_en[j] && (!w_found || (w_d < w_best_d))) begin
            w_found     = 1'b1;
            w_best_d    = w_d;
            w_found_idx = c_CH_W'(j);
         end
      end
   end

   always_comb begin
      w_edge_inc = r_edge_cnt;
      w_sat_inc  = r_sat_flag;
      if (w_rise) begin
         if (r_edge_cnt == c_CNT_MAX)
            w_sat_inc = 1'b1;
         else
            w_edge_inc = r_edge_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ch_ptr_nxt    = r_ch_ptr;
      w_gate_nxt      = r_gate_cnt;
      w_edge_nxt      = r_edge_cnt;
      w_sat_flag_nxt  = r_sat_flag;
      w_res_data_nxt  = r_res_data;
      w_res_ch_nxt    = r_res_ch;
      w_res_valid_nxt = r_res_valid;
      w_res_sat_nxt   = r_res_sat;
`ifdef FREQ_MEAS_STUCK_EN
      w_res_stuck_nxt = r_res_stuck;
`endif
      case (r_state)
         ST_IDLE: begin
            if (run)
               w_state_nxt = ST_SELECT;
         end
         ST_SELECT: begin
            if (!w_found) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_ch_ptr_nxt   = w_found_idx;
               w_gate_nxt     = '0;
               w_edge_nxt     = '0;
               w_sat_flag_nxt = 1'b0;
               w_state_nxt    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            // Synchronizer still holds the previous channel; edges are not counted.
            if (r_gate_cnt == c_SETTLE_LAST) begin
               w_gate_nxt  = '0;
               w_state_nxt = ST_GATE;
            end else begin
               w_gate_nxt = r_gate_cnt + 1'b1;
            end
         end
         ST_GATE: begin
            w_gate_nxt     = r_gate_cnt + 1'b1;
            w_edge_nxt     = w_edge_inc;
            w_sat_flag_nxt = w_sat_inc;
            if (r_gate_cnt == c_GATE_LAST) begin
               w_res_valid_nxt = 1'b1;
               w_res_ch_nxt    = r_ch_ptr;
               w_state_nxt     = ST_REPORT;
`ifdef FREQ_MEAS_STUCK_EN
               if (w_edge_inc == '0) begin
                  w_res_data_nxt  = c_CNT_MAX;
                  w_res_sat_nxt   = 1'b0;
                  w_res_stuck_nxt = 1'b1;
               end else begin
                  w_res_data_nxt  = w_edge_inc;
                  w_res_sat_nxt   = w_sat_inc;
                  w_res_stuck_nxt = 1'b0;
               end
`else
               w_res_data_nxt = w_edge_inc;
               w_res_sat_nxt  = w_sat_inc;
`endif
            end
         end
         ST_REPORT: begin
            if (res_ready) begin
               w_res_valid_nxt = 1'b0;
               w_ch_ptr_nxt    = w_ptr_inc;
               w_state_nxt     = run ? ST_SELECT : ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ch_ptr    <= '0;
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_hist      <= 1'b0;
         r_gate_cnt  <= '0;
         r_edge_cnt  <= '0;
         r_sat_flag  <= 1'b0;
         r_res_data  <= '0;
         r_res_ch    <= '0;
         r_res_valid <= 1'b0;
         r_res_sat   <= 1'b0;
`ifdef FREQ_MEAS_STUCK_EN
         r_res_stuck <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_ch_ptr    <= w_ch_ptr_nxt;
         r_sync1     <= sig_in[r_ch_ptr];
         r_sync2     <= r_sync1;
         r_hist      <= r_sync2;
         r_gate_cnt  <= w_gate_nxt;
         r_edge_cnt  <= w_edge_nxt;
         r_sat_flag  <= w_sat_flag_nxt;
         r_res_data  <= w_res_data_nxt;
         r_res_ch    <= w_res_ch_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_res_sat   <= w_res_sat_nxt;
`ifdef FREQ_MEAS_STUCK_EN
         r_res_stuck <= w_res_stuck_nxt;
`endif
      end
   end

   assign res_data  = r_res_data;
   assign res_ch    = r_res_ch;
   assign res_valid = r_res_valid;
   assign sat       = r_res_sat;
   assign busy      = (r_state != ST_IDLE);
`ifdef FREQ_MEAS_STUCK_EN
   assign stuck     = r_res_stuck;
`endif

endmodule
`default_nettype wire
